mult_12_arbiter: RTL and testbench
==================================

// Module: mult_12_arbiter
// PURPOSE
//  Shares one pipelined 12-bit float multiplier (1/5/6 sign/exp/mant, bias 15, 3-cycle latency)
//  between NUM_REQ requesters. Round-robin issue, at most one operation per cycle.
//  Each operation carries an in-flight requester tag, and its result returns to the issuing
//  requester. Sits between the neuron compute lanes and the shared multiplier instance.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DATA_W    12  float width (fixed 12 for the multiplier in use)
//  MULT_LAT  3   multiplier latency, in edges, from operands sampled to result valid
// PORTS
//  clk_i          in   1               single clock, rising edge
//  rst_i          in   1               synchronous reset, active-high
//  hold_i         in   1               1 = issue no new grants; in-flight ops still drain
//  req_valid_i    in   NUM_REQ         per-requester operand valid
//  req_ready_o    out  NUM_REQ         one-hot grant; handshake = valid & ready
//  req_a_i        in   NUM_REQ*DATA_W  operand A; requester k at [k*DATA_W +: DATA_W]
//  req_b_i        in   NUM_REQ*DATA_W  operand B, same packing
//  mult_a_o       out  DATA_W          registered operand A to multiplier
//  mult_b_o       out  DATA_W          registered operand B to multiplier
//  mult_result_i  in   DATA_W          multiplier product
//  res_valid_o    out  NUM_REQ         one-hot, 1-cycle pulse: result for requester k
//  res_data_o     out  DATA_W          registered product, shared by all requesters
//  busy_o         out  1               1 while any op is in flight or res_valid_o is nonzero
// BEHAVIOUR
//  - Reset values: req_ready_o, mult_a_o, mult_b_o, res_valid_o, res_data_o, busy_o = 0;
//    RR pointer = 0; tag pipe empty.
//  - Arbitration (combinational): search req_valid_i from the pointer upward, mod NUM_REQ.
//    The first set bit gets req_ready_o. Nothing is granted if hold_i or rst_i is high.
//    req_ready_o depends on req_valid_i, so requesters must not drive valid from ready.
//  - On a handshake, the pointer moves to (grantee+1) mod NUM_REQ. With no grant, the pointer holds.
//  - Handshake in cycle 0 -> mult_a_o/mult_b_o hold those operands in cycle 1.
//    The multiplier samples them at the end of cycle 1, and mult_result_i is valid in cycle 1+MULT_LAT.
//    Result is registered to res_data_o with res_valid_o[k]=1 in cycle MULT_LAT+2 (5 at default).
//    Latency is fixed and independent of operand values, including zero, overflow and underflow.
//  - Tag pipe: MULT_LAT+1 stages of {valid, log2(NUM_REQ) tag}, shifted every cycle; no stall.
//    Throughput is 1 op/cycle. With NUM_REQ requesters all valid, each is granted once per NUM_REQ cycles.
//  - With no grant, the mult operand regs keep their old values (no toggling); tag valid = 0.
//  - No backpressure on results: a requester must accept res_valid_o in the cycle it is asserted.
//  - hold_i asserted mid-stream: grants stop the same cycle; in-flight results still deliver;
//    busy_o stays 1 until the last res_valid_o pulse has been driven.
//  - Reset mid-operation: all in-flight tags are dropped, no res_valid_o after reset, pointer = 0.
//  - Simultaneous grant and result in the same cycle are independent (separate pipe stages).
//  - A single requester may hold valid continuously; it is granted every cycle if it is alone.
// CONFIGURATION
//  MULT_ARB_STATS_EN defined:
//   - adds per-requester 16-bit saturating grant counters, cleared by rst_i.
//   - adds ports stat_sel_i (in, log2(NUM_REQ)) and stat_cnt_o (out, 16): registered read, 1 cycle latency.
//   - a counter holds at 0xFFFF once it reaches it.
//  MULT_ARB_STATS_EN undefined: no counters and no stat ports; all other behaviour identical.
// STRUCTURE
//  Shared package float12_pkg: FP12_W=12, FP12_EXP_W=5, FP12_MAN_W=6, FP12_BIAS=15,
//   FP12_MULT_LAT=3, FP12_ONE=12'h3C0.
//  One sub-module: rr_arbiter (NUM_REQ-wide, pointer input, one-hot grant output, combinational).
//  Pointer register, tag pipe, operand registers and result register live in mult_12_arbiter.
//  The multiplier is instantiated outside this block; this block only drives its ports.
// TESTING (bench pairs this block with the real multiplier)
//  1 Single op: req 0 A=12'h3C0 (1.0), B=12'h400 (2.0), cycle 0
//    -> res_valid_o=4'b0001, res_data_o=12'h400 in cycle 5; busy_o=1 in cycles 1..5.
//  2 Full contention: all 4 valid, A=B=12'h3E0 (1.5) held 8 cycles
//    -> grant order 0,1,2,3,0,1,2,3; each result is 12'h408 (2.25), tagged to its requester.
//  3 Round-robin fairness: req 2 valid only, then reqs 0 and 3 valid
//    -> after granting 2, the next grant goes to 3, then 0.
//  4 Zero operand: A=12'h000, B=12'h5C0 -> res_data_o=12'h000 with the same 5-cycle latency.
//  5 hold_i=1 for 3 cycles during contention -> req_ready_o=0 for those cycles;
//    the two in-flight results still deliver; pointer unchanged.
//  6 rst_i pulse 2 cycles after 3 back-to-back grants
//    -> no res_valid_o afterwards; all outputs 0; next grant goes to req 0.

Source files
------------

// File: rtl/float12_pkg.sv
// Format constants for the 12-bit float (1 sign / 5 exp / 6 mant, bias 15) and the
// shared pipelined multiplier that mult_12_arbiter feeds.
package float12_pkg;

  localparam int FP12_W        = 12;
  localparam int FP12_EXP_W    = 5;
  localparam int FP12_MAN_W    = 6;
  localparam int FP12_BIAS     = 15;
  localparam int FP12_MULT_LAT = 3;

  localparam logic [FP12_W-1:0] FP12_ONE = 12'h3C0;

  typedef logic [FP12_W-1:0] fp12_t;

  localparam int GRANT_CNT_W = 16;
  localparam logic [GRANT_CNT_W-1:0] GRANT_CNT_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or above ptr (mod N)
// wins; returns the one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  // One extra bit so ptr + offset (< 2N) never wraps before the modulo fold.
  logic [IDX_W:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!grant_vld && req[cand[IDX_W-1:0]]) begin
        grant_vld                 = 1'b1;
        grant_idx                 = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_12_arbiter.sv
// Round-robin front end sharing one 3-cycle 12-bit float multiplier between NUM_REQ lanes.
// Optional per-requester grant statistics are enabled with MULT_ARB_STATS_EN.
module mult_12_arbiter
  import float12_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = FP12_W,
  parameter int MULT_LAT = FP12_MULT_LAT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        hold_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b_i,
  output logic [DATA_W-1:0]           mult_a_o,
  output logic [DATA_W-1:0]           mult_b_o,
  input  logic [DATA_W-1:0]           mult_result_i,
  output logic [NUM_REQ-1:0]          res_valid_o,
  output logic [DATA_W-1:0]           res_data_o,
  output logic                        busy_o
`ifdef MULT_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0]  stat_sel_i,
  output logic [GRANT_CNT_W-1:0]      stat_cnt_o
`endif
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } tag_t;

  logic [TAG_W-1:0]   ptr;
  logic [TAG_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] arb_req;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [NUM_REQ-1:0] res_onehot;

  // Stage s holds the tag of the op whose operands reached the multiplier s cycles ago.
  tag_t tag_pipe [MULT_LAT+1];

  assign arb_req = (hold_i || rst_i) ? '0 : req_valid_i;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (TAG_W)
  ) u_rr_arbiter (
    .req       (arb_req),
    .ptr       (ptr),
    .grant     (req_ready_o),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign next_ptr = (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == TAG_W'(k)) begin
        sel_a = req_a_i[k*DATA_W +: DATA_W];
        sel_b = req_b_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    res_onehot = '0;
    if (tag_pipe[MULT_LAT].vld) begin
      res_onehot[tag_pipe[MULT_LAT].tag] = 1'b1;
    end
  end

  always_comb begin
    busy_o = |res_valid_o;
    for (int s = 0; s <= MULT_LAT; s++) begin
      busy_o = busy_o | tag_pipe[s].vld;
    end
  end

  // Operand regs only load on a grant so the multiplier inputs stay quiet when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr         <= '0;
      mult_a_o    <= '0;
      mult_b_o    <= '0;
      res_valid_o <= '0;
      res_data_o  <= '0;
      for (int s = 0; s <= MULT_LAT; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      if (grant_vld) begin
        ptr      <= next_ptr;
        mult_a_o <= sel_a;
        mult_b_o <= sel_b;
      end
      tag_pipe[0].vld <= grant_vld;
      tag_pipe[0].tag <= grant_idx;
      for (int s = 1; s <= MULT_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      res_valid_o <= res_onehot;
      if (tag_pipe[MULT_LAT].vld) begin
        res_data_o <= mult_result_i;
      end
    end
  end

`ifdef MULT_ARB_STATS_EN
  logic [GRANT_CNT_W-1:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_cnt_o <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        grant_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_vld && grant_idx == TAG_W'(k) && grant_cnt[k] != GRANT_CNT_MAX) begin
          grant_cnt[k] <= grant_cnt[k] + 1'b1;
        end
      end
      stat_cnt_o <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (stat_sel_i == TAG_W'(k)) begin
          stat_cnt_o <= grant_cnt[k];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_12_arbiter.sv
// Directed bench for mult_12_arbiter paired with a behavioural 3-stage fp12 multiplier.
module tb_mult_12_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_a;
  logic [47:0] req_b;
  logic [11:0] mult_a;
  logic [11:0] mult_b;
  logic [11:0] mult_result;
  logic [3:0]  res_valid;
  logic [11:0] res_data;
  logic        busy;
`ifdef MULT_ARB_STATS_EN
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  mult_12_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .hold_i        (hold),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .mult_a_o      (mult_a),
    .mult_b_o      (mult_b),
    .mult_result_i (mult_result),
    .res_valid_o   (res_valid),
    .res_data_o    (res_data),
    .busy_o        (busy)
`ifdef MULT_ARB_STATS_EN
    ,
    .stat_sel_i    (stat_sel),
    .stat_cnt_o    (stat_cnt)
`endif
  );

  function automatic logic [11:0] fp_mul(input logic [11:0] a, input logic [11:0] b);
    logic        s;
    int          e;
    logic [13:0] p;
    logic [5:0]  m;
    s = a[11] ^ b[11];
    if (a[10:6] == 5'd0 || b[10:6] == 5'd0) return {s, 11'd0};
    p = 14'({1'b1, a[5:0]}) * 14'({1'b1, b[5:0]});
    e = int'(a[10:6]) + int'(b[10:6]) - 15;
    if (p[13]) begin
      e = e + 1;
      m = p[12:7];
    end else begin
      m = p[11:6];
    end
    if (e >= 31) return {s, 5'd30, 6'h3F};
    if (e <= 0) return {s, 11'd0};
    return {s, e[4:0], m};
  endfunction

  logic [11:0] m1 = '0, m2 = '0, m3 = '0;
  always @(posedge clk) begin
    m1 <= fp_mul(mult_a, mult_b);
    m2 <= m1;
    m3 <= m2;
  end
  assign mult_result = m3;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [3:0]  valid;
    logic        hold;
    logic [47:0] a;
    logic [47:0] b;
    logic [3:0]  ready;
    logic [3:0]  rv;
    logic [11:0] rd;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] valid, input logic h, input logic [47:0] a,
                     input logic [47:0] b, input logic [3:0] ready, input logic [3:0] rv,
                     input logic [11:0] rd, input logic bz);
    vec_t v;
    v.valid = valid; v.hold = h; v.a = a; v.b = b;
    v.ready = ready; v.rv = rv; v.rd = rd; v.busy = bz;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [3:0] rv, input logic [11:0] rd, input logic bz);
    add(4'b0000, 1'b0, '0, '0, 4'b0000, rv, rd, bz);
  endtask

  function automatic logic [47:0] rep4(input logic [11:0] x);
    return {4{x}};
  endfunction

  localparam logic [47:0] MIX_A = 48'h420_3E0_400_3C0;

  initial begin
    // single op on req 0, then zero operand on req 3 (pointer returns to 0)
    add(4'b0001, 1'b0, rep4(12'h3C0), rep4(12'h400), 4'b0001, 4'b0000, 12'h000, 1'b0);
    repeat (4) idle(4'b0000, 12'h000, 1'b1);
    idle(4'b0001, 12'h400, 1'b1);
    add(4'b1000, 1'b0, rep4(12'h000), rep4(12'h5C0), 4'b1000, 4'b0000, 12'h000, 1'b0);
    repeat (4) idle(4'b0000, 12'h000, 1'b1);
    idle(4'b1000, 12'h000, 1'b1);
    // full contention, 1.5 * 1.5
    add(4'b1111, 1'b0, rep4(12'h3E0), rep4(12'h3E0), 4'b0001, 4'b0000, 12'h000, 1'b0);
    add(4'b1111, 1'b0, rep4(12'h3E0), rep4(12'h3E0), 4'b0010, 4'b0000, 12'h000, 1'b1);
    add(4'b1111, 1'b0, rep4(12'h3E0), rep4(12'h3E0), 4'b0100, 4'b0000, 12'h000, 1'b1);
    add(4'b1111, 1'b0, rep4(12'h3E0), rep4(12'h3E0), 4'b1000, 4'b0000, 12'h000, 1'b1);
    add(4'b1111, 1'b0, rep4(12'h3E0), rep4(12'h3E0), 4'b0001, 4'b0000, 12'h000, 1'b1);
    add(4'b1111, 1'b0, rep4(12'h3E0), rep4(12'h3E0), 4'b0010, 4'b0001, 12'h408, 1'b1);
    add(4'b1111, 1'b0, rep4(12'h3E0), rep4(12'h3E0), 4'b0100, 4'b0010, 12'h408, 1'b1);
    add(4'b1111, 1'b0, rep4(12'h3E0), rep4(12'h3E0), 4'b1000, 4'b0100, 12'h408, 1'b1);
    idle(4'b1000, 12'h408, 1'b1);
    idle(4'b0001, 12'h408, 1'b1);
    idle(4'b0010, 12'h408, 1'b1);
    idle(4'b0100, 12'h408, 1'b1);
    idle(4'b1000, 12'h408, 1'b1);
    idle(4'b0000, 12'h000, 1'b0);
    // fairness: 2 alone, then 0 and 3 -> 3 before 0
    add(4'b0100, 1'b0, rep4(12'h3C0), rep4(12'h3C0), 4'b0100, 4'b0000, 12'h000, 1'b0);
    add(4'b1001, 1'b0, rep4(12'h3C0), rep4(12'h3C0), 4'b1000, 4'b0000, 12'h000, 1'b1);
    add(4'b1001, 1'b0, rep4(12'h3C0), rep4(12'h3C0), 4'b0001, 4'b0000, 12'h000, 1'b1);
    idle(4'b0000, 12'h000, 1'b1);
    idle(4'b0000, 12'h000, 1'b1);
    idle(4'b0100, 12'h3C0, 1'b1);
    idle(4'b1000, 12'h3C0, 1'b1);
    idle(4'b0001, 12'h3C0, 1'b1);
    idle(4'b0000, 12'h000, 1'b0);
    // hold during contention, distinct operands per requester, B = 2.0
    add(4'b1111, 1'b0, MIX_A, rep4(12'h400), 4'b0010, 4'b0000, 12'h000, 1'b0);
    add(4'b1111, 1'b0, MIX_A, rep4(12'h400), 4'b0100, 4'b0000, 12'h000, 1'b1);
    repeat (3) add(4'b1111, 1'b1, MIX_A, rep4(12'h400), 4'b0000, 4'b0000, 12'h000, 1'b1);
    add(4'b1111, 1'b0, MIX_A, rep4(12'h400), 4'b1000, 4'b0010, 12'h440, 1'b1);
    add(4'b1111, 1'b1, MIX_A, rep4(12'h400), 4'b0000, 4'b0100, 12'h420, 1'b1);
    repeat (3) add(4'b1111, 1'b1, MIX_A, rep4(12'h400), 4'b0000, 4'b0000, 12'h000, 1'b1);
    add(4'b1111, 1'b1, MIX_A, rep4(12'h400), 4'b0000, 4'b1000, 12'h460, 1'b1);
    add(4'b1111, 1'b1, MIX_A, rep4(12'h400), 4'b0000, 4'b0000, 12'h000, 1'b0);

    rst = 1'b1; hold = 1'b0; req_valid = 4'b1111;
    req_a = rep4(12'h3C0); req_b = rep4(12'h400);
`ifdef MULT_ARB_STATS_EN
    stat_sel = 2'd0;
`endif
    step();
    check("reset ready", {44'd0, req_ready}, 48'd0);
    check("reset res_valid", {44'd0, res_valid}, 48'd0);
    check("reset busy", {47'd0, busy}, 48'd0);
    check("reset mult_a", {36'd0, mult_a}, 48'd0);
    check("reset res_data", {36'd0, res_data}, 48'd0);
    step();
    rst = 1'b0; req_valid = 4'b0000;

    for (int i = 0; i < vecs.size(); i++) begin
      req_valid = vecs[i].valid;
      hold      = vecs[i].hold;
      req_a     = vecs[i].a;
      req_b     = vecs[i].b;
      #1;
      check($sformatf("row%0d ready", i), {44'd0, req_ready}, {44'd0, vecs[i].ready});
      check($sformatf("row%0d res_valid", i), {44'd0, res_valid}, {44'd0, vecs[i].rv});
      if (vecs[i].rv != 4'b0000)
        check($sformatf("row%0d res_data", i), {36'd0, res_data}, {36'd0, vecs[i].rd});
      check($sformatf("row%0d busy", i), {47'd0, busy}, {47'd0, vecs[i].busy});
      step();
    end

    // reset two cycles after three back-to-back grants
    hold = 1'b0; req_valid = 4'b1111;
    req_a = rep4(12'h3C0); req_b = rep4(12'h400);
    #1; check("b2b grant0", {44'd0, req_ready}, 48'h1); step();
    #1; check("b2b grant1", {44'd0, req_ready}, 48'h2); step();
    #1; check("b2b grant2", {44'd0, req_ready}, 48'h4); step();
    req_valid = 4'b0000;
    #1; check("b2b busy", {47'd0, busy}, 48'h1); step();
    rst = 1'b1; req_valid = 4'b1111;
    #1; check("ready in reset", {44'd0, req_ready}, 48'd0); step();
    rst = 1'b0; req_valid = 4'b0000;
    #1;
    check("post-rst mult_a", {36'd0, mult_a}, 48'd0);
    check("post-rst mult_b", {36'd0, mult_b}, 48'd0);
    check("post-rst res_data", {36'd0, res_data}, 48'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("post-rst res_valid %0d", i), {44'd0, res_valid}, 48'd0);
      check($sformatf("post-rst busy %0d", i), {47'd0, busy}, 48'd0);
      #1;
      step();
    end
    req_valid = 4'b1111;
    #1; check("post-rst first grant", {44'd0, req_ready}, 48'h1); step();

    // a lone requester holding valid is granted every cycle
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      #1; check($sformatf("lone grant %0d", i), {44'd0, req_ready}, 48'h2); step();
    end
    req_valid = 4'b0000;
`ifdef MULT_ARB_STATS_EN
    stat_sel = 2'd1;
`endif
    #1;
    check("lone res0 valid", {44'd0, res_valid}, 48'h1);
    check("lone res0 data", {36'd0, res_data}, 48'h400);
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("lone res valid %0d", i), {44'd0, res_valid}, 48'h2);
      check($sformatf("lone res data %0d", i), {36'd0, res_data}, 48'h400);
`ifdef MULT_ARB_STATS_EN
      if (i == 0) check("stat count req1", {32'd0, stat_cnt}, 48'd4);
`endif
      step();
    end
    #1; check("final busy", {47'd0, busy}, 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
